sha_1_pad: RTL and testbench



---
 rtl/sha_1_pad_pkg.sv | 21 ++
 rtl/sha_1_pad_word.sv | 22 ++
 rtl/sha_1_pad.sv | 140 ++++++++++++++
 tb/tb_sha_1_pad.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sha_1_pad_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha_1_pad_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam logic [31:0] PAD_WORD    = 32'h8000_0000;
  localparam int          BLOCK_WORDS = 16;
  localparam int          LEN_HI_IDX  = 14;
  localparam int          LEN_LO_IDX  = 15;

  // Byte counts above four are treated as a full word.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] bytes);
    clamp_bytes = (bytes > 3'd4) ? 3'd4 : bytes;
  endfunction

endpackage

// File: rtl/sha_1_pad_word.sv
// Builds the final partial word: keeps the first n bytes, inserts 0x80, zero-fills the rest.
module sha_1_pad_word
  import sha_1_pad_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [1:0]  n,
  output logic [31:0] word
);

  // Byte-lane mask and marker insertion
  always_comb begin
    word = PAD_WORD;
    case (n)
      2'd0:    word = PAD_WORD;
      2'd1:    word = {in_data[31:24], 24'h80_0000};
      2'd2:    word = {in_data[31:16], 16'h8000};
      2'd3:    word = {in_data[31:8], 8'h80};
      default: word = PAD_WORD;
    endcase
  end

endmodule

// File: rtl/sha_1_pad.sv
// SHA-1 padder: collects message words, appends marker/zeros/bit length, emits 16-word blocks.
module sha_1_pad
  import sha_1_pad_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic [31:0] block_data [15:0],
  output logic        block_valid,
  input  logic        block_ready,
  output logic        block_last
);

  state_t             state_r;
  state_t             ret_r;
  logic [3:0]         idx_r;
  logic [LEN_W-1:0]   len_r;
  logic               pad_pending_r;
  logic [2:0]         n_s;
  logic [31:0]        word_s;
  logic [63:0]        len_ext_s;

  assign n_s      = clamp_bytes(in_bytes);
  assign in_ready = (state_r == FILL) && !reset;

  sha_1_pad_word u_word (
    .in_data (in_data),
    .n       (n_s[1:0]),
    .word    (word_s)
  );

  // Zero-extend the bit length into the 64-bit trailer field
  always_comb begin
    len_ext_s = 64'd0;
    len_ext_s[LEN_W-1:0] = len_r;
  end

  // Padding state machine; block_data doubles as the assembly buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FILL;
      ret_r         <= FILL;
      idx_r         <= 4'd0;
      len_r         <= '0;
      pad_pending_r <= 1'b0;
      block_valid   <= 1'b0;
      block_last    <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        block_data[i] <= 32'h0;
      end
    end else begin
      case (state_r)
        FILL: begin
          if (in_valid) begin
            idx_r <= idx_r + 4'd1;
            if (in_last) begin
              len_r <= len_r + LEN_W'({n_s, 3'b000});
              if (n_s == 3'd4) begin
                block_data[idx_r] <= in_data;
                pad_pending_r     <= 1'b1;
              end else begin
                block_data[idx_r] <= word_s;
                pad_pending_r     <= 1'b0;
              end
              if (idx_r == 4'd15) begin
                state_r     <= EMIT;
                ret_r       <= PAD;
                block_valid <= 1'b1;
              end else begin
                state_r <= PAD;
              end
            end else begin
              len_r             <= len_r + LEN_W'(32'd32);
              block_data[idx_r] <= in_data;
              if (idx_r == 4'd15) begin
                state_r     <= EMIT;
                ret_r       <= FILL;
                block_valid <= 1'b1;
              end else begin
                state_r <= FILL;
              end
            end
          end else begin
            state_r <= FILL;
          end
        end
        PAD: begin
          // A pending marker must be placed even if it lands in the length slots
          if (pad_pending_r || (idx_r != 4'(LEN_HI_IDX))) begin
            block_data[idx_r] <= pad_pending_r ? PAD_WORD : 32'h0;
            pad_pending_r     <= 1'b0;
            idx_r             <= idx_r + 4'd1;
            if (idx_r == 4'd15) begin
              state_r     <= EMIT;
              ret_r       <= PAD;
              block_valid <= 1'b1;
            end else begin
              state_r <= PAD;
            end
          end else begin
            state_r <= LEN;
          end
        end
        LEN: begin
          block_data[LEN_HI_IDX] <= len_ext_s[63:32];
          block_data[LEN_LO_IDX] <= len_ext_s[31:0];
          state_r                <= EMIT;
          ret_r                  <= FILL;
          block_last             <= 1'b1;
          block_valid            <= 1'b1;
        end
        EMIT: begin
          if (block_ready) begin
            block_valid <= 1'b0;
            idx_r       <= 4'd0;
            state_r     <= ret_r;
            if (ret_r == FILL) begin
              len_r      <= '0;
              block_last <= 1'b0;
            end else begin
              block_last <= block_last;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_pad.sv
// Directed bench for sha_1_pad with hand-computed padded blocks.
module tb_sha_1_pad;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic [31:0] block_data [15:0];
  logic        block_valid;
  logic        block_ready;
  logic        block_last;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_w [16];

  sha_1_pad #(.LEN_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_ready_wait", 64'(in_ready), 64'd1);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    in_bytes = nb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
  endtask

  task automatic wait_block(input string tag, input int exp_lat);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!block_valid && cnt < 100);
    check({tag, "_valid"}, 64'(block_valid), 64'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(cnt), 64'(exp_lat));
  endtask

  task automatic check_block(input string tag, input logic exp_last);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_w%0d", tag, i), 64'(block_data[i]), 64'(exp_w[i]));
    end
    check({tag, "_last"}, 64'(block_last), 64'(exp_last));
  endtask

  task automatic accept(input string tag, input int stall);
    int bad;
    for (int c = 0; c < stall; c++) begin
      bad = 0;
      for (int i = 0; i < 16; i++) if (block_data[i] !== exp_w[i]) bad++;
      check({tag, "_stall_stable"}, 64'(bad), 64'd0);
      check({tag, "_stall_valid"}, 64'(block_valid), 64'd1);
      check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    block_ready = 1'b1;
    @(posedge clk);
    #1;
    block_ready = 1'b0;
    check({tag, "_drop"}, 64'(block_valid), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    in_data     = 32'h0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_bytes    = 3'd0;
    block_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_valid", 64'(block_valid), 64'd0);
    check("rst_last", 64'(block_last), 64'd0);
    clear_exp();
    check_block("rst", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // "abc"
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_block("abc", 15);
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    check_block("abc", 1'b1);
    accept("abc", 0);

    // empty message, data bytes must be discarded
    send(32'hDEAD_BEEF, 1'b1, 3'd0);
    wait_block("empty", 15);
    clear_exp();
    exp_w[0] = 32'h8000_0000;
    check_block("empty", 1'b1);
    accept("empty", 0);

    // 55 bytes
    for (int i = 0; i < 13; i++) send(32'hA500_0000 | 32'(i), 1'b0, 3'd0);
    send(32'hAABB_CCDD, 1'b1, 3'd3);
    wait_block("b55", 2);
    clear_exp();
    for (int i = 0; i < 13; i++) exp_w[i] = 32'hA500_0000 | 32'(i);
    exp_w[13] = 32'hAABB_CC80;
    exp_w[15] = 32'h0000_01B8;
    check_block("b55", 1'b1);
    accept("b55", 0);

    // 56 bytes, with in_bytes=7 treated as a full word
    for (int i = 0; i < 13; i++) send(32'h5A00_0000 | 32'(i), 1'b0, 3'd0);
    send(32'h1122_3344, 1'b1, 3'd7);
    wait_block("b56a", -1);
    clear_exp();
    for (int i = 0; i < 13; i++) exp_w[i] = 32'h5A00_0000 | 32'(i);
    exp_w[13] = 32'h1122_3344;
    exp_w[14] = 32'h8000_0000;
    check_block("b56a", 1'b0);
    accept("b56a", 0);
    wait_block("b56b", 16);
    clear_exp();
    exp_w[15] = 32'h0000_01C0;
    check_block("b56b", 1'b1);
    accept("b56b", 0);

    // 64 bytes with consumer stalls
    for (int i = 0; i < 15; i++) send(32'hC0DE_0000 | 32'(i), 1'b0, 3'd0);
    send(32'hC0DE_000F, 1'b1, 3'd4);
    wait_block("b64a", -1);
    for (int i = 0; i < 16; i++) exp_w[i] = 32'hC0DE_0000 | 32'(i);
    check_block("b64a", 1'b0);
    accept("b64a", 10);
    wait_block("b64b", 16);
    clear_exp();
    exp_w[0]  = 32'h8000_0000;
    exp_w[15] = 32'h0000_0200;
    check_block("b64b", 1'b1);
    accept("b64b", 10);

    // reset in the middle of padding a 5-word message
    for (int i = 0; i < 4; i++) send(32'hBAD0_0000 | 32'(i), 1'b0, 3'd0);
    send(32'hBAD0_0004, 1'b1, 3'd4);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (block_valid) check("midrst_no_stale", 64'(block_valid), 64'd0);
    end
    check("midrst_quiet", 64'(block_valid), 64'd0);
    send(32'h6162_6300, 1'b1, 3'd3);
    wait_block("abc2", 15);
    clear_exp();
    exp_w[0]  = 32'h6162_6380;
    exp_w[15] = 32'h0000_0018;
    check_block("abc2", 1'b1);
    accept("abc2", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
